rule_match_encoder: RTL and testbench

//  Final stage of the header engine, downstream of the per-field lookups (source/destination IP,

---
 rtl/rule_match_encoder_pkg.sv | 14 +
 rtl/rule_match_encoder_chunk_lsb_encoder.sv | 22 ++
 rtl/rule_match_encoder.sv | 162 ++++++++++++++++
 tb/tb_rule_match_encoder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rule_match_encoder_pkg.sv
// Shared header-engine definitions: default rule count, rule-ID width and the
// encoder FSM state encoding.
package rule_match_encoder_pkg;

  localparam int BV_DEFAULT = 195;
  localparam int RULE_ID_W  = $clog2(BV_DEFAULT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_NOMATCH = 2'd2
  } state_e;

endpackage

// File: rtl/rule_match_encoder_chunk_lsb_encoder.sv
// Combinational lowest-set-bit finder for one scan chunk of the rule vector.
// 'any' flags a non-empty chunk; 'idx' is the lowest set position (0 when empty).
module chunk_lsb_encoder #(
  parameter int W  = 16,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  vec,
  output logic          any,
  output logic [IW-1:0] idx
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    any = |vec;
    idx = '0;
    // Walk downwards so the lowest set bit is the last (winning) assignment.
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/rule_match_encoder.sv
// Final header-engine stage: ANDs the five per-field rule vectors and streams
// matching rule IDs lowest-first over valid/ready. Optional counters: HDR_STATS_EN.
module rule_match_encoder
  import rule_match_encoder_pkg::*;
#(
  parameter int BVSIZE    = BV_DEFAULT,
  parameter int CHUNK     = 16,
  parameter int MAX_MATCH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [BVSIZE-1:0]         srcip_bv,
  input  logic [BVSIZE-1:0]         dstip_bv,
  input  logic [BVSIZE-1:0]         srcport_bv,
  input  logic [BVSIZE-1:0]         dstport_bv,
  input  logic [BVSIZE-1:0]         proto_bv,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(BVSIZE)-1:0] out_rule_id,
  output logic                      out_nomatch,
  output logic                      out_last,
  output logic                      out_trunc
`ifdef HDR_STATS_EN
  ,
  output logic [31:0]               hdr_cnt,
  output logic [31:0]               match_cnt,
  output logic [15:0]               drop_cnt
`endif
);

  localparam int NCHUNK = (BVSIZE + CHUNK - 1) / CHUNK;
  localparam int PADW   = NCHUNK * CHUNK;
  localparam int PTR_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int IDX_W  = (CHUNK > 1) ? $clog2(CHUNK) : 1;
  localparam int POS_W  = $clog2(PADW);
  localparam int CNT_W  = $clog2(MAX_MATCH + 1);
  localparam int IDW    = $clog2(BVSIZE);

  state_e            state_q, state_d;
  logic [PADW-1:0]   work_q, work_d;
  logic [PTR_W-1:0]  chunk_q, chunk_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [BVSIZE-1:0] match_all;
  logic [PADW-1:0]   match_pad;
  logic [CHUNK-1:0]  cur_chunk;
  logic [CHUNK-1:0]  chunk_rest;
  logic              chunk_any;
  logic [IDX_W-1:0]  lsb_idx;
  logic [POS_W-1:0]  rule_pos;
  logic [PADW-1:0]   work_clr;
  logic              is_last_bit;
  logic              at_cap;

  assign match_all = srcip_bv & dstip_bv & srcport_bv & dstport_bv & proto_bv;
  // Top chunk is zero-padded so every chunk slice stays in range.
  assign match_pad = PADW'(match_all);
  assign cur_chunk = work_q[int'(chunk_q) * CHUNK +: CHUNK];

  chunk_lsb_encoder #(
    .W  (CHUNK),
    .IW (IDX_W)
  ) u_lsb (
    .vec (cur_chunk),
    .any (chunk_any),
    .idx (lsb_idx)
  );

  assign rule_pos    = POS_W'(int'(chunk_q) * CHUNK + int'(lsb_idx));
  assign work_clr    = work_q & ~(PADW'(1) << rule_pos);
  assign chunk_rest  = cur_chunk & ~(CHUNK'(1) << lsb_idx);
  assign is_last_bit = (work_clr == '0);
  assign at_cap      = (count_q == CNT_W'(MAX_MATCH - 1));

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    chunk_d     = chunk_q;
    count_d     = count_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_rule_id = '0;
    out_nomatch = 1'b0;
    out_last    = 1'b0;
    out_trunc   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = match_pad;
          chunk_d = '0;
          count_d = '0;
          state_d = (match_pad == '0) ? ST_NOMATCH : ST_SCAN;
        end
      end

      ST_NOMATCH: begin
        out_valid   = 1'b1;
        out_nomatch = 1'b1;
        out_last    = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end

      ST_SCAN: begin
        if (!chunk_any) begin
          chunk_d = chunk_q + 1'b1;
        end else begin
          out_valid   = 1'b1;
          out_rule_id = IDW'(rule_pos);
          out_last    = is_last_bit || at_cap;
          out_trunc   = at_cap && !is_last_bit;
          if (out_ready) begin
            work_d  = work_clr;
            count_d = count_q + 1'b1;
            if (out_last) begin
              state_d = ST_IDLE;
            end else if (chunk_rest == '0) begin
              // Step past the drained chunk now so adjacent chunks stream back to back.
              chunk_d = chunk_q + 1'b1;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the work vector
  // is ordinary state (not a memory array), so it is cleared with everything else.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      chunk_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      chunk_q <= chunk_d;
      count_q <= count_d;
    end
  end

`ifdef HDR_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hdr_cnt   <= '0;
      match_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (in_valid && in_ready)                          hdr_cnt   <= hdr_cnt + 32'd1;
      if (state_q == ST_SCAN && out_valid && out_ready)  match_cnt <= match_cnt + 32'd1;
      if (in_valid && !in_ready)                         drop_cnt  <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rule_match_encoder.sv
// Directed self-checking bench for rule_match_encoder (default parameters).
// Counter checks are compiled in only when HDR_STATS_EN is defined.
module tb_rule_match_encoder;
  import rule_match_encoder_pkg::*;

  localparam int BV  = BV_DEFAULT;
  localparam int IDW = RULE_ID_W;

  logic           clk;
  logic           rst_n;
  logic [BV-1:0]  srcip_bv, dstip_bv, srcport_bv, dstport_bv, proto_bv;
  logic           in_valid;
  logic           in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [IDW-1:0] out_rule_id;
  logic           out_nomatch;
  logic           out_last;
  logic           out_trunc;
`ifdef HDR_STATS_EN
  logic [31:0]    hdr_cnt;
  logic [31:0]    match_cnt;
  logic [15:0]    drop_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  rule_match_encoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .srcip_bv    (srcip_bv),
    .dstip_bv    (dstip_bv),
    .srcport_bv  (srcport_bv),
    .dstport_bv  (dstport_bv),
    .proto_bv    (proto_bv),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rule_id (out_rule_id),
    .out_nomatch (out_nomatch),
    .out_last    (out_last),
    .out_trunc   (out_trunc)
`ifdef HDR_STATS_EN
    ,
    .hdr_cnt     (hdr_cnt),
    .match_cnt   (match_cnt),
    .drop_cnt    (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BV-1:0] bit_of(input int i);
    logic [BV-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_all(input logic [BV-1:0] v);
    srcip_bv   = v;
    dstip_bv   = v;
    srcport_bv = v;
    dstport_bv = v;
    proto_bv   = v;
  endtask

  // Present one header for a single cycle; the accept edge is the one inside.
  task automatic send();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_all(bit_of(3));

    // 1: reset held with in_valid high
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_last", out_last, 0);
      check("rst_rule_id", out_rule_id, 0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_idle", out_valid, 0);
    end

    // 2: matches {3,40}, chunk 1 is skipped
    set_all(bit_of(3) | bit_of(40));
    srcip_bv  = srcip_bv | bit_of(7);
    out_ready = 1'b1;
    send();
    check("t2_b0_valid", out_valid, 1);
    check("t2_b0_id", out_rule_id, 3);
    check("t2_b0_last", out_last, 0);
    check("t2_b0_inready", in_ready, 0);
    step();
    check("t2_skip_valid", out_valid, 0);
    step();
    check("t2_b1_valid", out_valid, 1);
    check("t2_b1_id", out_rule_id, 40);
    check("t2_b1_last", out_last, 1);
    check("t2_b1_trunc", out_trunc, 0);
    step();
    check("t2_idle_valid", out_valid, 0);
    check("t2_idle_ready", in_ready, 1);

    // 3: no common rule
    set_all(bit_of(6));
    srcport_bv = bit_of(5);
    send();
    check("t3_valid", out_valid, 1);
    check("t3_nomatch", out_nomatch, 1);
    check("t3_id", out_rule_id, 0);
    check("t3_last", out_last, 1);
    check("t3_trunc", out_trunc, 0);
    check("t3_inready", in_ready, 0);
    step();
    check("t3_idle_valid", out_valid, 0);
    check("t3_idle_ready", in_ready, 1);

    // 4: all rules match, truncated at 32 beats
    set_all('1);
    send();
    for (int i = 0; i < 32; i++) begin
      check("t4_valid", out_valid, 1);
      check("t4_id", out_rule_id, i);
      check("t4_nomatch", out_nomatch, 0);
      check("t4_last", out_last, (i == 31) ? 1 : 0);
      check("t4_trunc", out_trunc, (i == 31) ? 1 : 0);
      step();
    end
    check("t4_idle_valid", out_valid, 0);
    check("t4_idle_ready", in_ready, 1);

    // 5: backpressure on rule 194, with a dropped header meanwhile
    set_all(bit_of(194));
    out_ready = 1'b0;
    send();
    wait_valid(n);
    check("t5_latency", n, 12);
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_valid", out_valid, 1);
      check("t5_hold_id", out_rule_id, 194);
      check("t5_hold_last", out_last, 1);
      check("t5_hold_inready", in_ready, 0);
      in_valid = (i == 2);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("t5_acc_id", out_rule_id, 194);
    check("t5_acc_trunc", out_trunc, 0);
    step();
    check("t5_idle_valid", out_valid, 0);
    check("t5_idle_ready", in_ready, 1);
`ifdef HDR_STATS_EN
    check("t5_drop_cnt", drop_cnt, 1);
    check("t5_hdr_cnt", hdr_cnt, 4);
    check("t5_match_cnt", match_cnt, 2 + 32 + 1);
`endif

    // 6: reset mid-scan of {0,100}, then a clean header {100}
    set_all(bit_of(0) | bit_of(100));
    send();
    check("t6_b0_id", out_rule_id, 0);
    check("t6_b0_last", out_last, 0);
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check("t6_no_beat", out_valid, 0);
      check("t6_ready", in_ready, 1);
    end
    set_all(bit_of(100));
    send();
    wait_valid(n);
    check("t6_latency", n, 6);
    check("t6_id", out_rule_id, 100);
    check("t6_last", out_last, 1);
    check("t6_trunc", out_trunc, 0);
    step();
    check("t6_idle_ready", in_ready, 1);
`ifdef HDR_STATS_EN
    check("t6_hdr_cnt", hdr_cnt, 1);
    check("t6_match_cnt", match_cnt, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
